// File: rtl/cle_sram_arb.sv
// Label-SRAM arbiter: shares one SRAM port between the labeling engine (port 0) and the host (port 1),
// and runs a whole-memory clear before each frame. Define CLE_SRAM_ARB_RR_EN for round-robin arbitration.
module cle_sram_arb #(
   parameter int ADDR_W     = 10,
   parameter int DATA_W     = 8,
   parameter int READ_LAT   = 1,
   parameter int STARVE_MAX = 4,
   parameter int CLR_VAL    = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              p0_valid,
   output logic              p0_ready,
   input  logic              p0_we,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [DATA_W-1:0] p0_wdata,
   output logic              p0_rvalid,
   output logic [DATA_W-1:0] p0_rdata,
   input  logic              p1_valid,
   output logic              p1_ready,
   input  logic              p1_we,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [DATA_W-1:0] p1_wdata,
   output logic              p1_rvalid,
   output logic [DATA_W-1:0] p1_rdata,
   input  logic              clr_start,
   output logic              clr_done,
   output logic              busy,
   input  logic [DATA_W-1:0] sram_q,
   output logic [ADDR_W-1:0] sram_a,
   output logic [DATA_W-1:0] sram_d,
   output logic              sram_wen
);
   // state | meaning
   // SERVE | arbitrate port 0 / port 1 onto the SRAM
   // CLEAR | write CLR_VAL to every address, both ports held off
   typedef enum logic {SERVE, CLEAR} state_t;

   // tag stage k is visible in the cycle k edges after acceptance
   localparam int TAG_D = READ_LAT + 2;

   state_t            state_q, state_d;
   logic [ADDR_W:0]   clr_cnt_q, clr_cnt_d;
   logic [ADDR_W-1:0] a_d;
   logic [DATA_W-1:0] d_d;
   logic              wen_d, busy_d, done_d;
   logic              grant0, grant1, p1_pri, push;
   logic [TAG_D-1:0]  tag_v, tag_p;

`ifdef CLE_SRAM_ARB_RR_EN
   logic last_q;  // 1 = port 1 was granted most recently

   assign p1_pri = ~last_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)       last_q <= 1'b1;
      else if (grant0) last_q <= 1'b0;
      else if (grant1) last_q <= 1'b1;
   end
`else
   localparam int SW = $clog2(STARVE_MAX + 1);
   logic [SW-1:0] starve_q;

   assign p1_pri = (starve_q == SW'(STARVE_MAX));

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                    starve_q <= '0;
      else if (!p1_valid || grant1) starve_q <= '0;
      else if (!p1_pri)             starve_q <= starve_q + 1'b1;
   end
`endif

   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      grant0    = 1'b0;
      grant1    = 1'b0;
      a_d       = sram_a;
      d_d       = sram_d;
      wen_d     = 1'b1;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      case (state_q)
         SERVE: begin
            if (clr_start) begin
               state_d   = CLEAR;
               clr_cnt_d = '0;
            end else if (p1_valid && (!p0_valid || p1_pri)) begin
               grant1 = 1'b1;
               a_d    = p1_addr;
               d_d    = p1_wdata;
               wen_d  = ~p1_we;
            end else if (p0_valid) begin
               grant0 = 1'b1;
               a_d    = p0_addr;
               d_d    = p0_wdata;
               wen_d  = ~p0_we;
            end
         end
         CLEAR: begin
            // counter past the last address means the final write is on the pins now
            if (clr_cnt_q[ADDR_W]) begin
               state_d = SERVE;
               done_d  = 1'b1;
            end else begin
               a_d       = clr_cnt_q[ADDR_W-1:0];
               d_d       = DATA_W'(CLR_VAL);
               wen_d     = 1'b0;
               busy_d    = 1'b1;
               clr_cnt_d = clr_cnt_q + 1'b1;
            end
         end
         default: state_d = SERVE;
      endcase
   end

   assign push = (grant0 & ~p0_we) | (grant1 & ~p1_we);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= SERVE;
         clr_cnt_q <= '0;
         sram_a    <= '0;
         sram_d    <= '0;
         sram_wen  <= 1'b1;
         busy      <= 1'b0;
         clr_done  <= 1'b0;
         tag_v     <= '0;
         tag_p     <= '0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
         sram_a    <= a_d;
         sram_d    <= d_d;
         sram_wen  <= wen_d;
         busy      <= busy_d;
         clr_done  <= done_d;
         tag_v     <= {tag_v[TAG_D-2:0], push};
         tag_p     <= {tag_p[TAG_D-2:0], grant1};
      end
   end

   assign p0_ready  = grant0;
   assign p1_ready  = grant1;
   assign p0_rvalid = tag_v[TAG_D-1] & ~tag_p[TAG_D-1];
   assign p1_rvalid = tag_v[TAG_D-1] &  tag_p[TAG_D-1];
   assign p0_rdata  = sram_q;
   assign p1_rdata  = sram_q;

endmodule

// File: tb/tb_cle_sram_arb.sv
// Bench for cle_sram_arb: grant table, randomized traffic against a queue-based model, clear/reset sequences.
module tb_cle_sram_arb;
   logic       clk = 1'b0;
   logic       reset;
   logic       p0_valid, p0_ready, p0_we, p0_rvalid;
   logic [9:0] p0_addr;
   logic [7:0] p0_wdata, p0_rdata;
   logic       p1_valid, p1_ready, p1_we, p1_rvalid;
   logic [9:0] p1_addr;
   logic [7:0] p1_wdata, p1_rdata;
   logic       clr_start, clr_done, busy;
   logic [7:0] sram_q = 8'h00;
   logic [9:0] sram_a;
   logic [7:0] sram_d;
   logic       sram_wen;

   int n_cmp = 0;
   int n_bad = 0;

   cle_sram_arb dut (
      .clk(clk), .reset(reset),
      .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_we(p0_we), .p0_addr(p0_addr),
      .p0_wdata(p0_wdata), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
      .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_we(p1_we), .p1_addr(p1_addr),
      .p1_wdata(p1_wdata), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
      .clr_start(clr_start), .clr_done(clr_done), .busy(busy),
      .sram_q(sram_q), .sram_a(sram_a), .sram_d(sram_d), .sram_wen(sram_wen)
   );

   always #5 clk = ~clk;

   // synchronous SRAM with an output register: data for an address accepted at edge A is on sram_q from edge A+2
   logic [7:0] mem [1024];
   logic [7:0] qd = 8'h00;
   bit         mem_ok;
   always @(posedge clk) begin
      if (!mem_ok) begin
         for (int i = 0; i < 1024; i++) mem[i] <= 8'(i * 7 + 3);
         mem_ok <= 1'b1;
      end else begin
         if (!sram_wen) mem[sram_a] <= sram_d;
         qd     <= mem[sram_a];
         sram_q <= qd;
      end
   end

   logic [7:0] ref_mem [1024];

   typedef struct {logic v0; logic v1; logic r0; logic r1;} vec_t;
   vec_t tbl [15];

   typedef struct {int due; bit port; logic [7:0] data;} rd_t;
   rd_t rq[$];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // issue one request on a port; call just after a rising edge, returns just after the acceptance edge
   task automatic issue(input bit port, input bit we, input int addr, input int data);
      if (!port) begin
         p0_valid = 1'b1; p0_we = we; p0_addr = 10'(addr); p0_wdata = 8'(data);
      end else begin
         p1_valid = 1'b1; p1_we = we; p1_addr = 10'(addr); p1_wdata = 8'(data);
      end
      @(negedge clk);
      check(port ? "p1_ready_issue" : "p0_ready_issue", port ? p1_ready : p0_ready, 1);
      @(posedge clk); #1;
      p0_valid = 1'b0;
      p1_valid = 1'b0;
   endtask

   task automatic expect_rv(input bit port, input int data, input int delay);
      repeat (delay) @(posedge clk);
      @(negedge clk);
      check(port ? "p1_rvalid" : "p0_rvalid", port ? p1_rvalid : p0_rvalid, 1);
      check(port ? "p0_rvalid_quiet" : "p1_rvalid_quiet", port ? p0_rvalid : p1_rvalid, 0);
      check(port ? "p1_rdata" : "p0_rdata", port ? p1_rdata : p0_rdata, 32'(data));
   endtask

   initial begin
      int  starve, idx, busy_cnt, pin_err, rdy_err;
      bit  last, g0, g1, e0, e1, found, p1b;
      logic       exp_wen;
      logic [9:0] exp_a;

      reset = 1'b1;
      p0_valid = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
      p1_valid = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0;
      clr_start = 0;
      for (int i = 0; i < 1024; i++) ref_mem[i] = 8'(i * 7 + 3);

      tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b0};
      tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b0};
      for (int i = 0; i < 10; i++) begin
`ifdef CLE_SRAM_ARB_RR_EN
         p1b = (i % 2 == 0);
`else
         p1b = (i % 5 == 4);
`endif
         tbl[2 + i] = '{1'b1, 1'b1, !p1b, p1b};
      end
      tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b1};
      tbl[13] = '{1'b1, 1'b0, 1'b1, 1'b0};
      tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0};

      // reset values
      repeat (3) @(posedge clk);
      #1;
      check("rst_sram_a", sram_a, 0);
      check("rst_sram_d", sram_d, 0);
      check("rst_sram_wen", sram_wen, 1);
      check("rst_clr_done", clr_done, 0);
      check("rst_busy", busy, 0);
      check("rst_rvalid", {p0_rvalid, p1_rvalid}, 0);
      reset = 1'b0;

      // write then read address 5
      @(posedge clk); #1;
      issue(0, 1, 5, 7);
      check("wr_sram_a", sram_a, 5);
      check("wr_sram_d", sram_d, 7);
      check("wr_sram_wen", sram_wen, 0);
      issue(0, 0, 5, 0);
      check("wen_one_cycle", sram_wen, 1);
      @(negedge clk);
      check("rv_early0", p0_rvalid, 0);
      @(posedge clk); @(negedge clk);
      check("rv_early1", p0_rvalid, 0);
      expect_rv(0, 7, 1);
      @(posedge clk); @(negedge clk);
      check("rv_single_pulse", p0_rvalid, 0);

      // grant table, all writes
      @(posedge clk); #1;
      for (int i = 0; i < 15; i++) begin
         p0_valid = tbl[i].v0; p0_we = 1'b1; p0_addr = 10'(i);       p0_wdata = 8'(i);
         p1_valid = tbl[i].v1; p1_we = 1'b1; p1_addr = 10'(512 + i); p1_wdata = 8'(i);
         @(negedge clk);
         check("tbl_p0_ready", p0_ready, tbl[i].r0);
         check("tbl_p1_ready", p1_ready, tbl[i].r1);
         @(posedge clk); #1;
         check("tbl_sram_wen", sram_wen, !(tbl[i].r0 || tbl[i].r1));
         if (tbl[i].r0) check("tbl_sram_a0", sram_a, i);
         if (tbl[i].r1) check("tbl_sram_a1", sram_a, 512 + i);
      end
      p0_valid = 0; p1_valid = 0;

      // randomized traffic on addresses 900..915 against a transaction-level model
      starve = 0; last = 1'b0; exp_wen = 1'b1; exp_a = 10'd13;
      for (int k = 0; k < 306; k++) begin
         if (k < 300) begin
            p0_valid = 1'($urandom_range(0, 1)); p0_we = 1'($urandom_range(0, 1));
            p0_addr = 10'(900 + $urandom_range(0, 15)); p0_wdata = 8'($urandom);
            p1_valid = 1'($urandom_range(0, 1)); p1_we = 1'($urandom_range(0, 1));
            p1_addr = 10'(900 + $urandom_range(0, 15)); p1_wdata = 8'($urandom);
         end else begin
            p0_valid = 0; p1_valid = 0;
         end
         @(negedge clk);
`ifdef CLE_SRAM_ARB_RR_EN
         g1 = p1_valid && (!p0_valid || !last);
`else
         g1 = p1_valid && (!p0_valid || starve >= 4);
`endif
         g0 = p0_valid && !g1;
         check("rnd_p0_ready", p0_ready, g0);
         check("rnd_p1_ready", p1_ready, g1);
         check("rnd_sram_wen", sram_wen, exp_wen);
         check("rnd_sram_a", sram_a, exp_a);
         e0 = rq.size() > 0 && rq[0].due == k && !rq[0].port;
         e1 = rq.size() > 0 && rq[0].due == k && rq[0].port;
         check("rnd_p0_rvalid", p0_rvalid, e0);
         check("rnd_p1_rvalid", p1_rvalid, e1);
         if (e0) check("rnd_p0_rdata", p0_rdata, rq[0].data);
         if (e1) check("rnd_p1_rdata", p1_rdata, rq[0].data);
         if (e0 || e1) void'(rq.pop_front());
`ifdef CLE_SRAM_ARB_RR_EN
         if (g0) last = 1'b0;
         else if (g1) last = 1'b1;
`else
         if (!p1_valid || g1) starve = 0;
         else if (starve < 4) starve++;
`endif
         exp_wen = 1'b1;
         if (g0) begin
            exp_a = p0_addr; exp_wen = !p0_we;
            if (p0_we) ref_mem[p0_addr] = p0_wdata;
            else rq.push_back('{k + 3, 1'b0, ref_mem[p0_addr]});
         end
         if (g1) begin
            exp_a = p1_addr; exp_wen = !p1_we;
            if (p1_we) ref_mem[p1_addr] = p1_wdata;
            else rq.push_back('{k + 3, 1'b1, ref_mem[p1_addr]});
         end
         @(posedge clk); #1;
      end
      check("rnd_reads_drained", rq.size(), 0);

      // back-to-back reads across ports
      @(posedge clk); #1;
      issue(0, 1, 1, 8'h11);
      issue(1, 1, 2, 8'h22);
      issue(0, 1, 3, 8'h33);
      issue(0, 0, 1, 0);
      issue(1, 0, 2, 0);
      issue(0, 0, 3, 0);
      expect_rv(0, 8'h11, 0);
      expect_rv(1, 8'h22, 1);
      expect_rv(0, 8'h33, 1);

      // full clear with both ports requesting throughout
      @(posedge clk); #1;
      p0_valid = 1; p0_we = 0; p1_valid = 1; p1_we = 0; clr_start = 1;
      @(negedge clk);
      check("clr_start_wins", {p0_ready, p1_ready}, 0);
      @(posedge clk); #1;
      clr_start = 0;
      idx = 0; busy_cnt = 0; pin_err = 0; rdy_err = 0; found = 0;
      for (int i = 0; i < 1100 && !found; i++) begin
         @(negedge clk);
         if (clr_done) begin
            found = 1; p0_valid = 0; p1_valid = 0;
         end else begin
            if (p0_ready || p1_ready) rdy_err++;
            if (busy) begin
               if (sram_a != 10'(idx) || sram_wen || sram_d != 8'h00) pin_err++;
               idx++; busy_cnt++;
            end
         end
      end
      p0_valid = 0; p1_valid = 0;
      check("clr_done_seen", found, 1);
      check("clr_busy_cycles", busy_cnt, 1024);
      check("clr_pin_errors", pin_err, 0);
      check("clr_ready_errors", rdy_err, 0);
      @(negedge clk);
      check("clr_done_pulse", clr_done, 0);
      check("clr_busy_end", busy, 0);
      @(posedge clk); #1;
      issue(1, 0, 1023, 0);
      expect_rv(1, 0, 2);

      // read in flight when the clear starts
      @(posedge clk); #1;
      issue(0, 1, 600, 8'hA5);
      issue(1, 0, 600, 0);
      clr_start = 1;
      @(posedge clk); #1;
      clr_start = 0;
      expect_rv(1, 8'hA5, 1);
      @(negedge clk);
      check("clr_after_read_busy", busy, 1);

      // reset lands mid-clear at address 300
      found = 0;
      for (int i = 0; i < 400 && !found; i++) begin
         @(negedge clk);
         if (busy && sram_a == 10'd300) found = 1;
      end
      check("clr_reach_300", found, 1);
      reset = 1'b1;
      #1;
      check("rst_mid_wen", sram_wen, 1);
      check("rst_mid_busy", busy, 0);
      check("rst_mid_done", clr_done, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      found = 0;
      repeat (10) begin
         @(negedge clk);
         if (clr_done || busy) found = 1;
      end
      check("rst_no_done", found, 0);
      @(posedge clk); #1;
      clr_start = 1;
      @(posedge clk); #1;
      clr_start = 0;
      found = 0;
      for (int i = 0; i < 5 && !found; i++) begin
         @(negedge clk);
         if (busy) found = 1;
      end
      check("restart_busy", found, 1);
      check("restart_addr0", sram_a, 0);
      found = 0;
      for (int i = 0; i < 1100 && !found; i++) begin
         @(negedge clk);
         if (clr_done) found = 1;
      end
      check("restart_done", found, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
